// File: rtl/qenc_pkg.sv
// Shared definitions for the quadrature encoder reader:
// register map, STATUS/CTRL bit positions and the 4x step decoder.
package qenc_pkg;

  localparam logic [1:0] ADDR_POS    = 2'd0;
  localparam logic [1:0] ADDR_VEL    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_ERR   = 0;
  localparam int ST_DIR   = 1;
  localparam int ST_OVF   = 2;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILL
  } step_t;

  // Position of {A,B} along the forward cycle 00->01->11->10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    unique case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Distance along the cycle: 1 ahead = fwd, 1 behind = rev,
  // 2 apart means both channels flipped at once.
  function automatic step_t decode_step(input logic [1:0] prev,
                                        input logic [1:0] cur);
    logic [1:0] d;
    step_t      s;
    d = gray_idx(cur) - gray_idx(prev);
    unique case (d)
      2'd0:    s = STEP_NONE;
      2'd1:    s = STEP_FWD;
      2'd2:    s = STEP_ILL;
      default: s = STEP_REV;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/qenc_input_filter.sv
// One encoder channel: 2-FF synchronizer plus stability filter.
// Ports: clk, reset, din (async pin), sync (synchronized raw), level (filtered).
module qenc_input_filter
  import qenc_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sff;
  logic [CW-1:0] cnt;

  // Synchronizer free-runs so reset can seed the filter from the pin.
  always_ff @(posedge clk) begin
    sff <= {sff[0], din};
  end

  assign sync = sff[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= sff[1];
      cnt   <= '0;
    end else if (sff[1] == level) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      level <= sff[1];
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quadrature_encoder_reader.sv
// Avalon-MM quadrature decoder: position, windowed velocity, status, control.
// Ports: clk, reset, avs_address/read/readdata/write/writedata, enc_a, enc_b.
module quadrature_encoder_reader
  import qenc_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int FILTER_LEN  = 4,
  parameter int VEL_WINDOW  = 50000,
  parameter int INVERT_DIR  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        enc_a,
  input  logic        enc_b
);

  localparam int W  = COUNT_WIDTH;
  localparam int WW = $clog2(VEL_WINDOW);
  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic a_sync, b_sync, a_lvl, b_lvl;

  qenc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .din   (enc_a),
    .sync  (a_sync),
    .level (a_lvl)
  );

  qenc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .din   (enc_b),
    .sync  (b_sync),
    .level (b_lvl)
  );

  logic [1:0]          prev;
  logic [1:0]          cur;
  step_t               st;
  logic                up, dn;
  logic signed [W-1:0] step_v;
  logic signed [W-1:0] pos, vel, acc, acc_nxt;
  logic [WW-1:0]       win_cnt;
  logic                win_last;
  logic                err, dir, ovf, en;
  logic                wr_pos, wr_status, wr_ctrl, clr;
  logic                pos_wrap;
  logic [31:0]         rd_mux;

  assign cur = {a_lvl, b_lvl};
  assign st  = decode_step(prev, cur);
  assign up  = (INVERT_DIR != 0) ? (st == STEP_REV) : (st == STEP_FWD);
  assign dn  = (INVERT_DIR != 0) ? (st == STEP_FWD) : (st == STEP_REV);

  always_comb begin
    step_v = '0;
    if (up) step_v = W'(1);
    if (dn) step_v = '1;
  end

  assign pos_wrap = (up && pos == MAXV) || (dn && pos == MINV);

  // Accumulator clamps instead of wrapping.
  always_comb begin
    acc_nxt = acc + step_v;
    if ((up && acc == MAXV) || (dn && acc == MINV)) acc_nxt = acc;
  end

  assign win_last  = (win_cnt == WW'(VEL_WINDOW - 1));
  assign wr_pos    = avs_write && (avs_address == ADDR_POS);
  assign wr_status = avs_write && (avs_address == ADDR_STATUS);
  assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
  assign clr       = wr_ctrl && avs_writedata[CTRL_CLR];

  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      ADDR_POS:    rd_mux = 32'(pos);
      ADDR_VEL:    rd_mux = 32'(vel);
      ADDR_STATUS: rd_mux = {29'd0, ovf, dir, err};
      default:     rd_mux = {31'd0, en};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev         <= {a_sync, b_sync};
      pos          <= '0;
      vel          <= '0;
      acc          <= '0;
      win_cnt      <= '0;
      err          <= 1'b0;
      dir          <= 1'b0;
      ovf          <= 1'b0;
      en           <= 1'b1;
      avs_readdata <= '0;
    end else begin
      prev <= cur;

      if (clr || win_last) win_cnt <= '0;
      else                 win_cnt <= win_cnt + 1'b1;

      if (win_last) vel <= en ? acc_nxt : '0;

      if (clr || win_last) acc <= '0;
      else if (en)         acc <= acc_nxt;

      if (wr_pos)  pos <= avs_writedata[W-1:0];
      else if (clr) pos <= '0;
      else if (en)  pos <= pos + step_v;

      // Sticky flags: a same-cycle set beats the write-1 clear.
      err <= (st == STEP_ILL) ||
             (err && !(wr_status && avs_writedata[ST_ERR]));
      ovf <= (en && pos_wrap && !wr_pos && !clr) ||
             (ovf && !(wr_status && avs_writedata[ST_OVF]));

      if (up || dn) dir <= dn;

      if (wr_ctrl) en <= avs_writedata[CTRL_EN];

      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule
